fifo_sync_v2: RTL

FIFO_SYNC_V2 -- requirements
Module: fifo_sync_v2

---
 rtl/fifo_sync_v2.sv | 90 +++++++++
 1 files changed

// File: rtl/fifo_sync_v2.sv
// fifo_sync_v2: synchronous FIFO with registered count, threshold flags, sticky error flags
// and optional first-word-fall-through read port.
module fifo_sync_v2 #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] din,
    input  logic             read_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = CW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_v2: DEPTH must be a power of 2 and >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_v2: WIDTH must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_v2: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_v2: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync_v2: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr, rd_ptr;
    logic             rd_acc, wr_acc;

    assign rd_acc       = read_en & ~empty;
    assign wr_acc       = write_en & (~full | rd_acc);
    assign full         = count == CW'(DEPTH);
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign empty        = count == '0;
    assign almost_empty = count <= CW'(AE_LEVEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
            count     <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
            overflow  <= (write_en & ~wr_acc) | (overflow & ~err_clr);
            underflow <= (read_en & empty) | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= din;
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = mem[rd_ptr[AW-1:0]];
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
        end
        assign dout = dout_q;
    end

    // Wrap-bit pointers and the count register must always agree on occupancy.
    always @(posedge clk) begin
        if (rst_n) assert (count == wr_ptr - rd_ptr);
    end
endmodule
